// File: rtl/gpio_quad_pkg.sv
// rtl/gpio_quad_pkg.sv - shared state/step types and the quadrature step decode function
package gpio_quad_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; any single-bit change not forward is reverse.
    function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_t s;
        s = STEP_NONE;
        if (prev_ab != cur_ab) begin
            if ((prev_ab ^ cur_ab) == 2'b11) begin
                s = STEP_ERR;
            end else begin
                case (prev_ab)
                    2'b00:   s = (cur_ab == 2'b01) ? STEP_FWD : STEP_REV;
                    2'b01:   s = (cur_ab == 2'b11) ? STEP_FWD : STEP_REV;
                    2'b11:   s = (cur_ab == 2'b10) ? STEP_FWD : STEP_REV;
                    default: s = (cur_ab == 2'b00) ? STEP_FWD : STEP_REV;
                endcase
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/gpio_quad_step.sv
// rtl/gpio_quad_step.sv - previous A/B register plus combinational step classification
module gpio_quad_step
    import gpio_quad_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_a,
    input  logic  i_b,
    output step_t o_step
);

    logic [1:0] r_prev_ab;
    logic [1:0] w_cur_ab;

    assign w_cur_ab = {i_a, i_b};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_ab <= 2'b00;
        end else begin
            r_prev_ab <= w_cur_ab;
        end
    end

    assign o_step = decode_step(r_prev_ab, w_cur_ab);

endmodule

// File: rtl/gpio_quad_decoder.sv
// rtl/gpio_quad_decoder.sv - x4 quadrature decoder with single-entry position stream
// Optional index clear on din_z rising edge when QUAD_INDEX_CLEAR_EN is defined.
module gpio_quad_decoder
    import gpio_quad_pkg::*;
#(
    parameter int CNTR_WIDTH = 32,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  din_a,
    input  logic                  din_b,
    input  logic                  din_z,
    input  logic                  clear,
    output logic [CNTR_WIDTH-1:0] position,
    output logic                  dir,
    output logic [ERR_WIDTH-1:0]  err_cnt,
    output logic                  ovf,
    output logic [CNTR_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    step_t                   w_step;
    logic                    w_run;
    logic                    w_index;
    logic                    w_change;
    logic [CNTR_WIDTH-1:0]   w_pos_nxt;
    logic [CNTR_WIDTH-1:0]   r_position;
    logic                    r_dir;
    logic [ERR_WIDTH-1:0]    r_err_cnt;
    logic                    r_ovf;
    logic [CNTR_WIDTH-1:0]   r_tdata;
    logic                    r_tvalid;

    gpio_quad_step u_step (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_a     (din_a),
        .i_b     (din_b),
        .o_step  (w_step)
    );

`ifdef QUAD_INDEX_CLEAR_EN
    logic r_z_prev;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_z_prev <= 1'b0;
        end else begin
            r_z_prev <= din_z;
        end
    end

    assign w_index = din_z & ~r_z_prev;
`else
    logic w_unused_z;
    assign w_unused_z = din_z;
    assign w_index    = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // The index clear overrides a same-cycle step; a change is any resulting position difference.
    always_comb begin
        w_run     = (r_state == ST_RUN) && !clear;
        w_pos_nxt = r_position;
        if (w_run) begin
            if (w_step == STEP_FWD) begin
                w_pos_nxt = r_position + CNTR_WIDTH'(1);
            end else if (w_step == STEP_REV) begin
                w_pos_nxt = r_position - CNTR_WIDTH'(1);
            end
            if (w_index) begin
                w_pos_nxt = '0;
            end
        end
        w_change = (w_pos_nxt != r_position);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_position <= '0;
            r_dir      <= 1'b0;
            r_err_cnt  <= '0;
            r_ovf      <= 1'b0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
        end else if (clear) begin
            r_position <= '0;
            r_err_cnt  <= '0;
            r_ovf      <= 1'b0;
            r_tvalid   <= 1'b0;
        end else begin
            r_position <= w_pos_nxt;
            if (w_run && (w_step == STEP_FWD)) begin
                r_dir <= 1'b1;
            end else if (w_run && (w_step == STEP_REV)) begin
                r_dir <= 1'b0;
            end
            if (w_run && (w_step == STEP_ERR) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_WIDTH'(1);
            end
            if (w_change) begin
                r_tdata  <= w_pos_nxt;
                r_tvalid <= 1'b1;
                if (r_tvalid && !m_axis_tready) begin
                    r_ovf <= 1'b1;
                end
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign position      = r_position;
    assign dir           = r_dir;
    assign err_cnt       = r_err_cnt;
    assign ovf           = r_ovf;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;

endmodule

// File: tb/tb_gpio_quad_decoder.sv
// tb/tb_gpio_quad_decoder.sv - vector table, corner sequences and randomized model check
module tb_gpio_quad_decoder;

    localparam int CW      = 32;
    localparam int EW      = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          din_a = 1'b0;
    logic          din_b = 1'b0;
    logic          din_z = 1'b0;
    logic          clear = 1'b0;
    logic          m_axis_tready = 1'b0;
    logic [CW-1:0] position;
    logic          dir;
    logic [EW-1:0] err_cnt;
    logic          ovf;
    logic [CW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;

    gpio_quad_decoder #(.CNTR_WIDTH(CW), .ERR_WIDTH(EW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .din_a         (din_a),
        .din_b         (din_b),
        .din_z         (din_z),
        .clear         (clear),
        .position      (position),
        .dir           (dir),
        .err_cnt       (err_cnt),
        .ovf           (ovf),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          a, b, z, clr, rdy;
        logic [CW-1:0] pos;
        logic          dir;
        logic [EW-1:0] err;
        logic          tv;
        logic          ovf;
        logic [CW-1:0] td;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic a, b, z, clr, rdy, input logic [CW-1:0] pos,
                                input logic d, input logic [EW-1:0] err, input logic tv, ov,
                                input logic [CW-1:0] td);
        vec_t v;
        v.a = a; v.b = b; v.z = z; v.clr = clr; v.rdy = rdy;
        v.pos = pos; v.dir = d; v.err = err; v.tv = tv; v.ovf = ov; v.td = td;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic a, b, z, clr, rdy);
        din_a = a; din_b = b; din_z = z; clear = clr; m_axis_tready = rdy;
        @(posedge aclk);
        #1;
    endtask

    // Reference model: A/B mapped to a 0..3 phase; the phase difference mod 4 gives the step.
    logic [1:0]    ab_of [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    bit            m_init;
    int            m_prev_ph;
    logic          m_zprev;
    logic [CW-1:0] m_pos, m_tdata;
    logic          m_dir, m_ovf, m_tv;
    int            m_err;

    function automatic int phase(input logic a, input logic b);
        for (int k = 0; k < 4; k++) if (ab_of[k] == {a, b}) return k;
        return 0;
    endfunction

    task automatic model_reset();
        m_init = 1; m_prev_ph = 0; m_zprev = 0; m_pos = 0; m_tdata = 0;
        m_dir = 0; m_ovf = 0; m_tv = 0; m_err = 0;
    endtask

    task automatic model_step(input logic a, b, z, clr, rdy);
        int            cur, d;
        logic [CW-1:0] np;
        cur = phase(a, b);
        if (clr) begin
            m_pos = 0; m_err = 0; m_ovf = 0; m_tv = 0;
        end else begin
            np = m_pos;
            if (!m_init) begin
                d = (cur - m_prev_ph + 4) % 4;
                if (d == 1) begin np = m_pos + 1; m_dir = 1; end
                else if (d == 3) begin np = m_pos - 1; m_dir = 0; end
                else if (d == 2 && m_err < ERR_MAX) m_err++;
`ifdef QUAD_INDEX_CLEAR_EN
                if (z && !m_zprev) np = 0;
`endif
            end
            if (np != m_pos) begin
                if (m_tv && !rdy) m_ovf = 1;
                m_tdata = np;
                m_tv = 1;
            end else if (m_tv && rdy) begin
                m_tv = 0;
            end
            m_pos = np;
        end
        m_prev_ph = cur;
        m_zprev   = z;
        m_init    = 0;
    endtask

    initial begin
        logic [CW-1:0] idx_pos;
        logic [1:0]    ab;
        int            ph, r;
        logic          z, clr, rdy;

        // Reset values
        din_a = 1'b1; din_b = 1'b1;
        #12;
        chk("reset.pos", position, 0);
        chk("reset.err", err_cnt, 0);
        chk("reset.dir", dir, 0);
        chk("reset.tvalid", m_axis_tvalid, 0);
        chk("reset.tdata", m_axis_tdata, 0);
        chk("reset.ovf", ovf, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        // INIT absorbs AB=11
        for (int i = 0; i < 5; i++) add(1,1,0,0,1, 0,0,0,0,0,0);
        // Forward x4 with beats 1..4
        add(0,0,0,1,1, 0,0,0,0,0,0);
        add(0,1,0,0,1, 1,1,0,1,0,1);
        add(1,1,0,0,1, 2,1,0,1,0,2);
        add(1,0,0,0,1, 3,1,0,1,0,3);
        add(0,0,0,0,1, 4,1,0,1,0,4);
        add(0,0,0,0,1, 4,1,0,0,0,0);
        // Reverse wrap below zero, then an illegal two-bit change
        add(0,0,0,1,1, 0,1,0,0,0,0);
        add(1,0,0,0,1, 32'hFFFF_FFFF,0,0,1,0,32'hFFFF_FFFF);
        add(0,1,0,0,1, 32'hFFFF_FFFF,0,1,0,0,0);
        // Backpressure overwrite sets ovf, one beat on release
        add(0,0,0,1,0, 0,0,0,0,0,0);
        add(0,1,0,0,0, 1,1,0,1,0,1);
        add(1,1,0,0,0, 2,1,0,1,1,2);
        add(1,0,0,0,0, 3,1,0,1,1,3);
        add(1,0,0,0,1, 3,1,0,0,1,0);
        // Clear wins over a same-cycle step at position 7
        add(0,0,0,1,1, 0,1,0,0,0,0);
        for (int k = 1; k <= 7; k++) add(ab_of[k%4][1], ab_of[k%4][0], 0,0,1, k,1,0,1,0,k);
        add(0,0,0,1,1, 0,1,0,0,0,0);
        // Index edge with a forward step at position 5
        for (int k = 1; k <= 5; k++) add(ab_of[k%4][1], ab_of[k%4][0], 0,0,1, k,1,0,1,0,k);
`ifdef QUAD_INDEX_CLEAR_EN
        idx_pos = 0;
`else
        idx_pos = 6;
`endif
        add(1,1,1,0,1, idx_pos,1,0,1,0,idx_pos);
        add(1,1,0,0,1, idx_pos,1,0,0,0,0);
        add(1,1,1,0,1, idx_pos,1,0,0,0,0);
        add(1,1,0,0,1, idx_pos,1,0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].clr, vecs[i].rdy);
            chk($sformatf("vec%0d.pos", i), position, vecs[i].pos);
            chk($sformatf("vec%0d.dir", i), dir, vecs[i].dir);
            chk($sformatf("vec%0d.err", i), err_cnt, vecs[i].err);
            chk($sformatf("vec%0d.tvalid", i), m_axis_tvalid, vecs[i].tv);
            chk($sformatf("vec%0d.ovf", i), ovf, vecs[i].ovf);
            if (vecs[i].tv) chk($sformatf("vec%0d.tdata", i), m_axis_tdata, vecs[i].td);
        end

        // Error counter saturates at all-ones
        drive(0,0,0,1,1);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) drive(1,1,0,0,1);
            else            drive(0,0,0,0,1);
            if (i == 13) chk("sat.err14", err_cnt, 14);
            if (i == 14) chk("sat.err15", err_cnt, 15);
        end
        chk("sat.err_hold", err_cnt, 15);
        chk("sat.pos", position, 0);

        // Asynchronous reset drops a pending word immediately
        drive(0,0,0,1,0);
        drive(0,1,0,0,0);
        chk("arst.pre_tvalid", m_axis_tvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst.pos", position, 0);
        chk("arst.tvalid", m_axis_tvalid, 0);
        chk("arst.tdata", m_axis_tdata, 0);
        chk("arst.dir", dir, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();

        // Randomized run against the reference model
        ph = phase(din_a, din_b);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      ph = (ph + 1) % 4;
            else if (r < 7) ph = (ph + 3) % 4;
            else if (r == 7) ph = (ph + 2) % 4;
            ab  = ab_of[ph];
            z   = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            model_step(ab[1], ab[0], z, clr, rdy);
            drive(ab[1], ab[0], z, clr, rdy);
            chk($sformatf("rnd%0d.pos", n), position, m_pos);
            chk($sformatf("rnd%0d.dir", n), dir, m_dir);
            chk($sformatf("rnd%0d.err", n), err_cnt, m_err);
            chk($sformatf("rnd%0d.tvalid", n), m_axis_tvalid, m_tv);
            chk($sformatf("rnd%0d.ovf", n), ovf, m_ovf);
            if (m_tv) chk($sformatf("rnd%0d.tdata", n), m_axis_tdata, m_tdata);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
